// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: register file with write-through bypass, immediate
// extension, load-use bubble insertion, ID/EX register. Optional ID_STALL_CNT_EN adds o_stall_cnt.
module id_stage_pipe #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_CNT = 32,
    parameter int CTRL_W  = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_instr,
    input  logic [ADDR_W-1:0] i_pc4,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic              i_memread,
    input  logic              i_uses_rt,
    input  logic              i_signext,
    input  logic              i_flush,
    input  logic              i_wb_we,
    input  logic [4:0]        i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data_rs,
    output logic [DATA_W-1:0] o_data_rt,
    output logic [DATA_W-1:0] o_imm,
    output logic [4:0]        o_addr_rs,
    output logic [4:0]        o_addr_rt,
    output logic [4:0]        o_addr_rd,
    output logic [ADDR_W-1:0] o_pc4,
    output logic [CTRL_W-1:0] o_ctrl,
`ifdef ID_STALL_CNT_EN
    output logic [31:0]       o_stall_cnt,
`endif
    output logic              o_memread
);

    localparam int         IDX_W   = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;
    localparam logic [5:0] REG_LIM = 6'(REG_CNT);

    logic [DATA_W-1:0] regs [REG_CNT];
    logic [4:0]        addr_rs, addr_rt;
    logic [DATA_W-1:0] data_rs, data_rt, imm;
    logic              wb_hit, hazard, advance;
    logic              unused_ok;

    assign unused_ok = &{1'b0, i_instr[31:26]};
    assign addr_rs   = i_instr[25:21];
    assign addr_rt   = i_instr[20:16];

    function automatic logic in_range(input logic [4:0] a);
        return ({1'b0, a} < REG_LIM) && (a != 5'd0);
    endfunction

    assign wb_hit = i_wb_we && in_range(i_wb_addr);

    // Combinational read; a same-cycle writeback to the same index wins over the array.
    always_comb begin
        data_rs = '0;
        data_rt = '0;
        if (in_range(addr_rs))
            data_rs = (wb_hit && i_wb_addr == addr_rs) ? i_wb_data : regs[addr_rs[IDX_W-1:0]];
        if (in_range(addr_rt))
            data_rt = (wb_hit && i_wb_addr == addr_rt) ? i_wb_data : regs[addr_rt[IDX_W-1:0]];
    end

    assign imm = {{(DATA_W-16){i_signext & i_instr[15]}}, i_instr[15:0]};

    assign hazard  = i_valid && o_valid && o_memread && (o_addr_rt != 5'd0) &&
                     ((o_addr_rt == addr_rs) || (i_uses_rt && o_addr_rt == addr_rt));
    assign advance = !o_valid || i_ready;
    assign o_ready = !i_rst && (i_flush || (advance && !hazard));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
        end else if (wb_hit) begin
            regs[i_wb_addr[IDX_W-1:0]] <= i_wb_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid   <= 1'b0;
            o_data_rs <= '0;
            o_data_rt <= '0;
            o_imm     <= '0;
            o_addr_rs <= '0;
            o_addr_rt <= '0;
            o_addr_rd <= '0;
            o_pc4     <= '0;
            o_ctrl    <= '0;
            o_memread <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (advance) begin
            // A hazard leaves the load entry's payload in place and emits one bubble.
            o_valid <= hazard ? 1'b0 : i_valid;
            if (!hazard && i_valid) begin
                o_data_rs <= data_rs;
                o_data_rt <= data_rt;
                o_imm     <= imm;
                o_addr_rs <= addr_rs;
                o_addr_rt <= addr_rt;
                o_addr_rd <= i_instr[15:11];
                o_pc4     <= i_pc4;
                o_ctrl    <= i_ctrl;
                o_memread <= i_memread;
            end
        end
    end

`ifdef ID_STALL_CNT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_stall_cnt <= '0;
        else if (i_valid && !o_ready && o_stall_cnt != 32'hFFFF_FFFF)
            o_stall_cnt <= o_stall_cnt + 32'd1;
    end
`endif

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised instruction-decode stage with its ID/EX pipeline register. It contains the general-purpose register file with write-through bypass and immediate extension. It also detects load-use hazards and inserts bubbles, and handles valid/ready flow control and branch flush. Instruction-field decoding into control bits is done upstream and arrives as an opaque control bundle. The block sits between the IF/ID register and the execute stage.

Parameters:
DATA_W, 32, register/operand/immediate width (>=16)
ADDR_W, 32, PC width
REG_CNT, 32, number of architectural registers (2..32, power of 2); register 0 reads zero
CTRL_W, 12, width of opaque control bundle carried to EX

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_valid  in  1  upstream instruction valid
o_ready  out  1  stage accepts instruction this cycle
i_instr  in  32  instruction word
i_pc4  in  ADDR_W  PC+4 of instruction
i_ctrl  in  CTRL_W  control bundle, carried unchanged
i_memread  in  1  instruction is a load
i_uses_rt  in  1  instruction reads rt as a source
i_signext  in  1  1 = sign-extend imm, 0 = zero-extend
i_flush  in  1  discard ID/EX contents and the incoming instruction
i_wb_we  in  1  writeback enable
i_wb_addr  in  5  writeback register index
i_wb_data  in  DATA_W  writeback data
o_valid  out  1  ID/EX entry valid
i_ready  in  1  downstream accepts entry
o_data_rs  out  DATA_W  rs operand
o_data_rt  out  DATA_W  rt operand
o_imm  out  DATA_W  extended immediate
o_addr_rs  out  5  instr[25:21]
o_addr_rt  out  5  instr[20:16]
o_addr_rd  out  5  instr[15:11]
o_pc4  out  ADDR_W  registered PC+4
o_ctrl  out  CTRL_W  registered control bundle
o_memread  out  1  registered load flag

Behaviour:
- Reset (async, i_rst high): all registered outputs 0, all register-file entries 0. o_ready forced 0 while i_rst high.
- Register file write: on rising edge when i_wb_we=1, i_wb_addr!=0 and i_wb_addr<REG_CNT. Writes to index 0 or index >=REG_CNT are ignored.
- Register file read: combinational. Index 0 or index >=REG_CNT returns 0.
- Write-through bypass: if i_wb_we=1, i_wb_addr!=0 and i_wb_addr matches the read index, the read returns i_wb_data in the same cycle.
- Immediate: i_instr[15:0] extended to DATA_W; sign-extended if i_signext=1, else zero-filled.
- Hazard (combinational) is 1 when all of the following hold:
  - i_valid, o_valid and o_memread are 1, and o_addr_rt!=0;
  - o_addr_rt==i_instr[25:21], or (i_uses_rt=1 and o_addr_rt==i_instr[20:16]).
- Flow control:
  - advance = !o_valid | i_ready
  - o_ready = i_flush | (advance & !hazard)
- Register update, priority order:
  1. i_flush: o_valid<=0; incoming instruction dropped; payload don't-care.
  2. advance & hazard: o_valid<=0 (one bubble); payload held; upstream held by o_ready=0.
  3. advance & !hazard: o_valid<=i_valid; payload (operands, imm, addrs, pc4, ctrl, memread) captured only if i_valid=1, else held.
  4. !advance: all registers hold.
- Latency: one cycle from accept to o_valid. A load-use pair costs exactly one bubble, because the hazard clears once the load's entry leaves.
- Simultaneous writeback and read of the same register: the new data is captured via the bypass.
- Simultaneous i_flush and hazard: flush wins.
- Reset mid-stall: everything clears; no stale entry remains.

Optional Feature:
ID_STALL_CNT_EN
- Defined: adds o_stall_cnt (out, 32). It increments on every cycle where i_valid=1 and o_ready=0, saturates at 0xFFFFFFFF, and is cleared by i_rst.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then write r5=0x0000_1234 via WB; issue instr with rs=5 -> next cycle o_valid=1, o_data_rs=0x1234. Write to r0 -> r0 still reads 0.
- Same-cycle WB r7=0xDEAD_BEEF while accepting instr rs=7,rt=7 -> o_data_rs=o_data_rt=0xDEADBEEF.
- Load (i_memread=1, rt=3) accepted, then add rs=3 presented -> o_ready=0 for 1 cycle, bubble (o_valid=0) inserted, add accepted next cycle. Dependent rt with i_uses_rt=0 -> no stall.
- i_ready=0 for 3 cycles with a valid entry -> outputs stable, o_ready=0; i_ready=1 -> next instr captured.
- i_flush during valid entry plus incoming instr -> next cycle o_valid=0, o_ready was 1, incoming dropped.
- imm 0x8001: i_signext=1 -> 0xFFFF_8001; i_signext=0 -> 0x0000_8001. With ID_STALL_CNT_EN, the load-use case -> o_stall_cnt=1.
